// File: rtl/hemaia_clk_rst_pkg.sv
// Shared types and helpers for the hemaia clock/reset controller.
// Contents:
//   clk_prog_state_e : states of the divider reprogramming FSM
//   max_u            : unsigned maximum, usable in constant expressions
//   settle_cycles    : settle window after a divisor change
package hemaia_clk_rst_pkg;

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    IDLE    = 3'd1,
    PRE_RST = 3'd2,
    ISSUE   = 3'd3,
    SETTLE  = 3'd4,
    RELEASE = 3'd5,
    DONE    = 3'd6
  } clk_prog_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Two periods of the slower of the old and new divided clocks, plus margin.
  // A divisor of 0 (gated clock) contributes 0.
  function automatic int unsigned settle_cycles(input int unsigned old_div,
                                                input int unsigned new_div,
                                                input int unsigned margin);
    return 2 * max_u(old_div, new_div) + margin;
  endfunction

endpackage

// File: rtl/hemaia_clock_divider_programmer_if.sv
// Divisor-change request channel between the CSR logic and the divider programmer.
// Signals:
//   req_valid   : request valid (held by requester until accepted)
//   req_ready   : programmer can accept a request
//   req_divisor : requested divisor, 0 gates the clock
//   req_rst     : hold the divided domain in reset across this change
// Modports: master = requester, slave = programmer.
interface hemaia_clock_divider_programmer_if #(
  parameter int unsigned Width = 4
);

  logic             req_valid;
  logic             req_ready;
  logic [Width-1:0] req_divisor;
  logic             req_rst;

  modport master (
    output req_valid,
    output req_divisor,
    output req_rst,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_divisor,
    input  req_rst,
    output req_ready
  );

endinterface

// File: rtl/hemaia_clock_settle_timer.sv
// Loadable down-counter with a zero flag, used to time the programmer's wait states.
// A load of N makes zero_c rise after N cycles (N = 0 behaves as 1). The reset value is
// held raw, so the power-on window lasts ResetValue + 1 cycles.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   load_i       : load value_i this cycle
//   value_i      : number of cycles to wait
//   zero_c       : counter has expired (combinational from the count register)
module hemaia_clock_settle_timer #(
  parameter int unsigned CntWidth   = 6,
  parameter int unsigned ResetValue = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic [CntWidth-1:0] value_i,
  output logic                zero_c
);

  logic [CntWidth-1:0] cnt_q;

  // Loaded value is pre-decremented so the owning state lasts exactly value_i cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= CntWidth'(ResetValue);
    end else if (load_i) begin
      cnt_q <= (value_i == '0) ? '0 : value_i - CntWidth'(1);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CntWidth'(1);
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/hemaia_clock_divider_programmer.sv
// Initiator side of the divider reprogramming interface. Accepts divisor-change requests,
// issues the new divisor to one hemaia clock divider with a one-cycle valid pulse, waits a
// settle window and optionally holds the divided domain in reset across the change.
// Ports:
//   clk_i, rst_i    : undivided source clock, asynchronous active-high reset
//   req             : request channel (slave side)
//   divisor_o       : divisor to the divider, changes only when divisor_valid_o pulses
//   divisor_valid_o : single-cycle divisor update pulse
//   rst_domain_o    : active-high reset request for the divided domain
//   busy_o          : a change (or power-on sequence) is in progress
//   done_o          : single-cycle pulse when a change has completed
//   cur_divisor_o   : divisor in effect after the last completed change
module hemaia_clock_divider_programmer
  import hemaia_clk_rst_pkg::*;
#(
  parameter int unsigned MaxDivisionWidth = 4,
  parameter int unsigned DefaultDivision  = 1,
  parameter int unsigned SettleMargin     = 4,
  parameter int unsigned PreResetCycles   = 2,
  parameter int unsigned PostResetCycles  = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  hemaia_clock_divider_programmer_if.slave      req,
  output logic [MaxDivisionWidth-1:0]           divisor_o,
  output logic                                  divisor_valid_o,
  output logic                                  rst_domain_o,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic [MaxDivisionWidth-1:0]           cur_divisor_o
);

  localparam int unsigned W          = MaxDivisionWidth;
  localparam int unsigned InitCycles = 2 * DefaultDivision + SettleMargin;
  localparam int unsigned MaxLoad    = max_u(max_u(SettleMargin, PreResetCycles),
                                             max_u(PostResetCycles, InitCycles));
  localparam int unsigned CntW       = $clog2(2 * (2 ** W - 1) + MaxLoad + 1);

  clk_prog_state_e state_q, state_d;
  logic [W-1:0]    div_q, div_d;
  logic            rst_flag_q, rst_flag_d;
  logic            boot_q, boot_d;
  logic            ready_q;
  logic [W-1:0]    divisor_d, cur_d;
  logic            valid_d, rst_dom_d, done_d;
  logic            load;
  logic [CntW-1:0] load_val;
  logic            zero;

  hemaia_clock_settle_timer #(
    .CntWidth  (CntW),
    .ResetValue(InitCycles)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (load),
    .value_i(load_val),
    .zero_c (zero)
  );

  assign req.req_ready = ready_q;

  // Next state and next values of all registered outputs.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    rst_flag_d = rst_flag_q;
    boot_d     = boot_q;
    divisor_d  = divisor_o;
    cur_d      = cur_divisor_o;
    valid_d    = 1'b0;
    rst_dom_d  = rst_domain_o;
    done_d     = 1'b0;
    load       = 1'b0;
    load_val   = '0;

    unique case (state_q)
      INIT: begin
        if (zero) begin
          state_d  = RELEASE;
          load     = 1'b1;
          load_val = CntW'(PostResetCycles);
        end
      end
      IDLE: begin
        if (req.req_valid && ready_q) begin
          div_d      = req.req_divisor;
          rst_flag_d = req.req_rst;
          if (req.req_divisor == cur_divisor_o) begin
            state_d = DONE;
          end else if (req.req_rst) begin
            state_d  = PRE_RST;
            load     = 1'b1;
            load_val = CntW'(PreResetCycles);
          end else begin
            state_d = ISSUE;
          end
        end
      end
      PRE_RST: begin
        rst_dom_d = 1'b1;
        if (zero) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        divisor_d = div_q;
        valid_d   = 1'b1;
        load      = 1'b1;
        load_val  = CntW'(settle_cycles(32'(cur_divisor_o), 32'(div_q), SettleMargin));
        state_d   = SETTLE;
      end
      SETTLE: begin
        if (zero) begin
          if (rst_flag_q) begin
            state_d  = RELEASE;
            load     = 1'b1;
            load_val = CntW'(PostResetCycles);
          end else begin
            state_d = DONE;
          end
        end
      end
      RELEASE: begin
        if (zero) begin
          rst_dom_d = 1'b0;
          // The power-on release ends in IDLE without reporting a completed change.
          if (boot_q) begin
            boot_d  = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        cur_d   = div_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // State and output registers; ready/busy follow the next state so they never lag a handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= INIT;
      div_q           <= W'(DefaultDivision);
      rst_flag_q      <= 1'b0;
      boot_q          <= 1'b1;
      ready_q         <= 1'b0;
      divisor_o       <= W'(DefaultDivision);
      divisor_valid_o <= 1'b0;
      rst_domain_o    <= 1'b1;
      busy_o          <= 1'b1;
      done_o          <= 1'b0;
      cur_divisor_o   <= W'(DefaultDivision);
    end else begin
      state_q         <= state_d;
      div_q           <= div_d;
      rst_flag_q      <= rst_flag_d;
      boot_q          <= boot_d;
      ready_q         <= (state_d == IDLE);
      divisor_o       <= divisor_d;
      divisor_valid_o <= valid_d;
      rst_domain_o    <= rst_dom_d;
      busy_o          <= (state_d != IDLE);
      done_o          <= done_d;
      cur_divisor_o   <= cur_d;
    end
  end

endmodule

// File: tb/tb_hemaia_clock_divider_programmer.sv
// Self-checking bench for hemaia_clock_divider_programmer (W=4, default divisor 1,
// margin 4, pre/post reset 2 cycles).
module tb_hemaia_clock_divider_programmer;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] divisor_o;
  logic         divisor_valid_o;
  logic         rst_domain_o;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] cur_divisor_o;

  hemaia_clock_divider_programmer_if #(.Width(W)) bus ();

  hemaia_clock_divider_programmer #(
    .MaxDivisionWidth(W),
    .DefaultDivision (1),
    .SettleMargin    (4),
    .PreResetCycles  (2),
    .PostResetCycles (2)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req            (bus),
    .divisor_o      (divisor_o),
    .divisor_valid_o(divisor_valid_o),
    .rst_domain_o   (rst_domain_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .cur_divisor_o  (cur_divisor_o)
  );

  always #5 clk = ~clk;

  // One request: divisor, reset flag, edges from handshake to done_o, valid pulses,
  // cycles with rst_domain_o high.
  typedef struct {
    logic [W-1:0] div;
    logic         rst;
    int           lat;
    int           pulses;
    int           rsthi;
  } vec_t;

  vec_t vecs [8];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " ready"},      int'(bus.req_ready),     0);
    check({tag, " divisor"},    int'(divisor_o),         1);
    check({tag, " valid"},      int'(divisor_valid_o),   0);
    check({tag, " rst_domain"}, int'(rst_domain_o),      1);
    check({tag, " busy"},       int'(busy_o),            1);
    check({tag, " done"},       int'(done_o),            0);
    check({tag, " cur"},        int'(cur_divisor_o),     1);
  endtask

  // Power-on sequence: 7 INIT cycles (counter 6..0) + 2 RELEASE cycles.
  task automatic release_reset(input string tag);
    int k;
    int dones;
    int pulses;
    k = 0;
    dones = 0;
    pulses = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk);
      #1;
      if (done_o) dones++;
      if (divisor_valid_o) pulses++;
      if (!rst_domain_o) begin
        k = i;
        break;
      end
    end
    check({tag, " rst_domain release edge"}, k, 9);
    check({tag, " ready at release"}, int'(bus.req_ready), 1);
    check({tag, " busy at release"}, int'(busy_o), 0);
    @(posedge clk);
    #1;
    if (done_o) dones++;
    check({tag, " no done during init"}, dones, 0);
    check({tag, " no pulse during init"}, pulses, 0);
  endtask

  task automatic run_req(input logic [W-1:0] d, input logic r,
                         output int lat, output int pulses, output int rsthi);
    int w;
    lat = 0;
    pulses = 0;
    rsthi = 0;
    w = 0;
    @(negedge clk);
    while (!bus.req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    bus.req_divisor = d;
    bus.req_rst     = r;
    bus.req_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (divisor_valid_o) pulses++;
      if (rst_domain_o) rsthi++;
      if (done_o) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int pulses;
    int rsthi;
    int rdy_busy;
    logic [W-1:0] exp_div;

    // Non-reset change: ISSUE + S + DONE = S+2; reset change: S+6 with S+4 reset cycles.
    vecs[0] = '{4'd4,  1'b0, 14, 1, 0};   // 1 -> 4,  S = 12
    vecs[1] = '{4'd0,  1'b1, 18, 1, 16};  // 4 -> 0,  S = 12
    vecs[2] = '{4'd0,  1'b1, 1,  0, 0};   // 0 -> 0,  unchanged
    vecs[3] = '{4'd15, 1'b0, 36, 1, 0};   // 0 -> 15, S = 34
    vecs[4] = '{4'd15, 1'b0, 1,  0, 0};   // 15 -> 15
    vecs[5] = '{4'd3,  1'b1, 40, 1, 38};  // 15 -> 3, S = 34
    vecs[6] = '{4'd4,  1'b0, 14, 1, 0};   // 3 -> 4,  S = 12
    vecs[7] = '{4'd4,  1'b0, 1,  0, 0};   // 4 -> 4

    bus.req_valid   = 1'b0;
    bus.req_divisor = '0;
    bus.req_rst     = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    release_reset("boot");

    exp_div = 4'd1;
    for (int i = 0; i < 8; i++) begin
      run_req(vecs[i].div, vecs[i].rst, lat, pulses, rsthi);
      if (vecs[i].pulses != 0) exp_div = vecs[i].div;
      check($sformatf("v%0d latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d pulses", i), pulses, vecs[i].pulses);
      check($sformatf("v%0d rst cycles", i), rsthi, vecs[i].rsthi);
      check($sformatf("v%0d divisor", i), int'(divisor_o), int'(exp_div));
      check($sformatf("v%0d cur", i), int'(cur_divisor_o), int'(vecs[i].div));
    end

    // Request held during a change: 4 -> 2, then 2 -> 5 waiting behind it.
    @(negedge clk);
    bus.req_divisor = 4'd2;
    bus.req_rst     = 1'b0;
    bus.req_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus.req_divisor = 4'd5;
    rdy_busy = 0;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (bus.req_ready && !done_o) rdy_busy++;
      if (done_o) begin
        lat = k;
        break;
      end
    end
    check("hold first latency", lat, 14);
    check("hold ready while busy", rdy_busy, 0);
    check("hold first cur", int'(cur_divisor_o), 2);
    check("hold ready at done", int'(bus.req_ready), 1);
    @(posedge clk);
    #1;
    check("hold accepted ready", int'(bus.req_ready), 0);
    check("hold accepted busy", int'(busy_o), 1);
    bus.req_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (done_o) begin
        lat = k;
        break;
      end
    end
    check("hold second latency", lat, 16);
    check("hold second cur", int'(cur_divisor_o), 5);
    check("hold second divisor", int'(divisor_o), 5);

    // Reset in the middle of SETTLE for 5 -> 7.
    @(negedge clk);
    bus.req_divisor = 4'd7;
    bus.req_rst     = 1'b0;
    bus.req_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid divisor issued", int'(divisor_o), 7);
    check("mid busy", int'(busy_o), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_vals("mid");
    pulses = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (divisor_valid_o) pulses++;
    end
    check("mid no pulse in reset", pulses, 0);
    release_reset("mid");

    run_req(4'd2, 1'b0, lat, pulses, rsthi);
    check("after reset latency", lat, 10);
    check("after reset pulses", pulses, 1);
    check("after reset cur", int'(cur_divisor_o), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
